axis_vec_fork2: RTL and testbench
=================================

Name: axis_vec_fork2

Overview:
- Broadcasts one TILE_SIZE-wide vector stream to two independent consumers, for example the s/g datapaths or the EW update and gate paths. It is the split-side counterpart of the two-input vector join.
- Each branch has its own buffer, so one slow consumer does not stall the other until that branch's buffer is full.
- Every accepted input beat is delivered exactly once on each branch, in order.

Parameters:
- TILE_SIZE, 4, lanes per vector beat
- DATA_WIDTH, 16, bits per lane (raw, sign-agnostic)
- DEPTH, 4, entries per branch FIFO; power of two, at least 2
- ADDR_W, $clog2(DEPTH), FIFO pointer index width (derived)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid&&in_ready
- in_vec  in  [DATA_WIDTH-1:0] x TILE_SIZE  input vector
- a_valid  out  1  branch A beat valid
- a_ready  in  1  branch A consumer ready
- a_vec  out  [DATA_WIDTH-1:0] x TILE_SIZE  branch A vector
- b_valid  out  1  branch B beat valid
- b_ready  in  1  branch B consumer ready
- b_vec  out  [DATA_WIDTH-1:0] x TILE_SIZE  branch B vector
- a_count  out  ADDR_W+1  branch A occupancy, 0..DEPTH
- b_count  out  ADDR_W+1  branch B occupancy, 0..DEPTH

Behaviour:
- Reset (rst high, asynchronous): all pointers and counts go to 0; a_valid=0, b_valid=0; in_ready=1 from the first cycle after release. FIFO storage is not reset.
  - a_vec and b_vec are don't-care while their valid is low; benches must not check them.
- Reset asserted mid-traffic: all buffered beats are discarded and nothing is replayed.
- Push:
  - in_ready = !a_full && !b_full. It is a function of registered state only and never depends on a_ready, b_ready or in_valid.
  - On in_valid&&in_ready, in_vec is written into both FIFOs in the same edge.
- Latency: a beat accepted at edge N is visible on a_vec/b_vec, with the corresponding valid high, from edge N onward. That is one cycle after presentation; there is no combinational bypass.
- Pop: each branch FIFO is first-word-fall-through.
  - x_valid = !x_empty; x_vec = head entry.
  - On x_valid&&x_ready the read pointer advances. Branches pop independently.
- Pointers are ADDR_W+1 bits and wrap modulo 2*DEPTH.
  - empty: wr==rd.
  - full: MSBs differ and the low ADDR_W bits are equal.
  - count = wr - rd, modulo 2^(ADDR_W+1).
- Simultaneous push and pop on one branch: both take effect and the count is unchanged.
- When either branch is full, in_ready=0 even if that branch is popping in the same cycle. There is no same-cycle full pass-through; the space is seen the next cycle.
- Skew bound: |a_count - b_count| <= DEPTH at all times. No beat is ever dropped or duplicated.
- Valid stability: x_valid and x_vec stay stable while x_valid && !x_ready. in_ready is allowed to drop without in_valid.
- Both consumers permanently ready: steady throughput of 1 beat/cycle; both counts stay at 1 after the first push.

Decomposition:
- Package axis_vec_pkg: the vec_t typedef (logic [DATA_WIDTH-1:0] per lane, TILE_SIZE lanes) and a DEPTH power-of-two check function.
- One sub-module, axis_vec_fifo: a FWFT vector FIFO with push/pop/full/empty/count. It is instantiated twice.
- The top level holds only the push qualification (in_ready) and the port wiring.

Test Plan:
(TILE_SIZE=4, DATA_WIDTH=16, DEPTH=4)
- Reset with traffic: push 2 beats, assert rst asynchronously mid-cycle -> a_valid=b_valid=0 and counts=0 immediately; in_ready=1 after release; no stale beat appears later.
- Lockstep stream: in_vec={k,k+1,k+2,k+3} for k=0,4,..,60, a_ready=b_ready=1 -> both branches output all 16 beats in order, first beat 1 cycle after acceptance, 1 beat/cycle, counts never exceed 1.
- Stalled B: b_ready=0, a_ready=1, push 6 beats -> 4 accepted, then in_ready=0; b_count=4 and a_count=0. Raise b_ready -> B drains beats 0..3 in order, in_ready returns the cycle after B's first pop, and remaining beats 4,5 reach both branches.
- Full simultaneous event: A full, a_ready=1 and in_valid=1 in the same cycle -> no acceptance that cycle (in_ready=0), a_count goes 4->3; the push is accepted the next cycle and a_count returns to 4.
- Pointer wrap: 20 beats with random a_ready/b_ready (50% duty) -> both branches deliver all 20 beats in order with no loss or duplication, and |a_count-b_count| <= 4 throughout.
- Backpressure hold: a_valid high with a_ready=0 for 5 cycles -> a_vec held constant at the head value {0x0010,0x0011,0x0012,0x0013}.

Source files
------------

// File: rtl/axis_vec_pkg.sv
// Shared types and elaboration helpers for the vector stream fork.
package axis_vec_pkg;

  localparam int unsigned TILE_SIZE_DEF  = 4;
  localparam int unsigned DATA_WIDTH_DEF = 16;
  localparam int unsigned DEPTH_DEF      = 4;

  typedef logic [TILE_SIZE_DEF-1:0][DATA_WIDTH_DEF-1:0] vec_t;

  function automatic bit is_pow2(input int unsigned n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/axis_vec_fifo.sv
// First-word-fall-through vector FIFO with wrap-bit pointers and occupancy count.
module axis_vec_fifo
  import axis_vec_pkg::*;
#(
  parameter  int unsigned WIDTH  = 64,
  parameter  int unsigned DEPTH  = 4,
  localparam int unsigned ADDR_W = $clog2(DEPTH),
  localparam int unsigned PTR_W  = ADDR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PTR_W-1:0] count_o
);

  if (!is_pow2(DEPTH)) begin : g_depth_chk
    $error("axis_vec_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic             do_push;
  logic             do_pop;

  // Wrap bit distinguishes full from empty when the index bits match.
  assign full_o  = (wr_q[ADDR_W] != rd_q[ADDR_W]) &&
                   (wr_q[ADDR_W-1:0] == rd_q[ADDR_W-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign count_o = wr_q - rd_q;
  assign rdata_o = mem_q[rd_q[ADDR_W-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + PTR_W'(1);
    if (do_pop)  rd_d = rd_q + PTR_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage is deliberately left unreset; entries are only read once written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[ADDR_W-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/axis_vec_fork2.sv
// Broadcasts one vector stream to two independently back-pressured branches.
module axis_vec_fork2
  import axis_vec_pkg::*;
#(
  parameter  int unsigned TILE_SIZE  = TILE_SIZE_DEF,
  parameter  int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter  int unsigned DEPTH      = DEPTH_DEF,
  localparam int unsigned ADDR_W     = $clog2(DEPTH),
  localparam int unsigned VEC_W      = TILE_SIZE * DATA_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [TILE_SIZE-1:0][DATA_WIDTH-1:0]  in_vec,
  output logic                                  a_valid,
  input  logic                                  a_ready,
  output logic [TILE_SIZE-1:0][DATA_WIDTH-1:0]  a_vec,
  output logic                                  b_valid,
  input  logic                                  b_ready,
  output logic [TILE_SIZE-1:0][DATA_WIDTH-1:0]  b_vec,
  output logic [ADDR_W:0]                       a_count,
  output logic [ADDR_W:0]                       b_count
);

  logic a_full, a_empty;
  logic b_full, b_empty;
  logic push;

  // Accept only when both branches have room, judged on registered state.
  assign in_ready = !a_full && !b_full;
  assign push     = in_valid && in_ready;
  assign a_valid  = !a_empty;
  assign b_valid  = !b_empty;

  axis_vec_fifo #(.WIDTH(VEC_W), .DEPTH(DEPTH)) u_fifo_a (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (in_vec),
    .pop_i   (a_ready),
    .rdata_o (a_vec),
    .full_o  (a_full),
    .empty_o (a_empty),
    .count_o (a_count)
  );

  axis_vec_fifo #(.WIDTH(VEC_W), .DEPTH(DEPTH)) u_fifo_b (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (in_vec),
    .pop_i   (b_ready),
    .rdata_o (b_vec),
    .full_o  (b_full),
    .empty_o (b_empty),
    .count_o (b_count)
  );

endmodule

// File: tb/tb_axis_vec_fork2.sv
// Randomized self-checking bench for axis_vec_fork2 against a queue-based broadcast model.
module tb_axis_vec_fork2;
  import axis_vec_pkg::*;

  localparam int unsigned DEPTH = DEPTH_DEF;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  vec_t       in_vec, a_vec, b_vec;
  logic       a_valid, a_ready, b_valid, b_ready;
  logic [2:0] a_count, b_count;

  vec_t qa[$], qb[$];        // expected contents of each branch
  vec_t sent[$], da[$], db[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  axis_vec_fork2 dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .a_valid(a_valid), .a_ready(a_ready), .a_vec(a_vec),
    .b_valid(b_valid), .b_ready(b_ready), .b_vec(b_vec),
    .a_count(a_count), .b_count(b_count)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input int unsigned k);
    mk = {16'(k), 16'(k + 1), 16'(k + 2), 16'(k + 3)};
  endfunction

  // Advance one clock, updating the model from the broadcast rules.
  task automatic tick(output bit acc);
    bit   push, popa, popb;
    vec_t v;
    v    = in_vec;
    push = in_valid && (qa.size() < DEPTH) && (qb.size() < DEPTH);
    popa = a_ready && (qa.size() > 0);
    popb = b_ready && (qb.size() > 0);
    if (a_valid && a_ready) da.push_back(a_vec);
    if (b_valid && b_ready) db.push_back(b_vec);
    @(posedge clk);
    if (popa) void'(qa.pop_front());
    if (popb) void'(qb.pop_front());
    if (push) begin
      qa.push_back(v);
      qb.push_back(v);
      sent.push_back(v);
    end
    acc = push;
    @(negedge clk);
  endtask

  task automatic drain();
    bit acc;
    in_valid = 1'b0;
    a_ready  = 1'b1;
    b_ready  = 1'b1;
    for (int i = 0; i < 20 && (qa.size() > 0 || qb.size() > 0); i++) tick(acc);
  endtask

  task automatic clear_sb();
    sent.delete(); da.delete(); db.delete();
  endtask

  task automatic test_reset();
    bit acc;
    total_cnt++;
    if (in_ready !== 1'b1 || a_valid !== 1'b0 || b_valid !== 1'b0 ||
        a_count !== 3'd0 || b_count !== 3'd0) begin
      $display("FAIL reset_state: rdy=%b av=%b bv=%b ac=%0d bc=%0d, want 1 0 0 0 0",
               in_ready, a_valid, b_valid, a_count, b_count);
    end else pass_cnt++;
    a_ready = 1'b0; b_ready = 1'b0; in_valid = 1'b1;
    in_vec = mk(40); tick(acc);
    in_vec = mk(44); tick(acc);
    in_valid = 1'b0;
    total_cnt++;
    if (a_count !== 3'd2 || b_count !== 3'd2) begin
      $display("FAIL reset_prefill: ac=%0d bc=%0d, want 2 2", a_count, b_count);
    end else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (a_valid !== 1'b0 || b_valid !== 1'b0 || a_count !== 3'd0 || b_count !== 3'd0) begin
      $display("FAIL reset_async: av=%b bv=%b ac=%0d bc=%0d, want 0 0 0 0",
               a_valid, b_valid, a_count, b_count);
    end else pass_cnt++;
    qa.delete(); qb.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total_cnt++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end else pass_cnt++;
    a_ready = 1'b1; b_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
        $display("FAIL reset_no_stale: cyc %0d av=%b bv=%b want 0 0", i, a_valid, b_valid);
      end else pass_cnt++;
      tick(acc);
    end
  endtask

  task automatic test_lockstep();
    int k = 0;
    int cyc = 0;
    bit acc;
    clear_sb();
    a_ready = 1'b1; b_ready = 1'b1;
    while ((k < 16 || qa.size() > 0 || qb.size() > 0) && cyc < 100) begin
      in_valid = (k < 16);
      in_vec   = mk(4 * k);
      total_cnt++;
      if (a_valid !== (qa.size() > 0) || b_valid !== (qb.size() > 0) ||
          (qa.size() > 0 && a_vec !== qa[0]) || (qb.size() > 0 && b_vec !== qb[0]) ||
          a_count > 3'd1 || b_count > 3'd1) begin
        $display("FAIL lockstep_cycle: cyc %0d av=%b bv=%b a=%h b=%h ac=%0d bc=%0d, want counts<=1 and heads %0d",
                 cyc, a_valid, b_valid, a_vec, b_vec, a_count, b_count, qa.size());
      end else pass_cnt++;
      tick(acc);
      if (acc) k++;
      cyc++;
    end
    total_cnt++;
    if (cyc != 17 || da != sent || db != sent || sent.size() != 16) begin
      $display("FAIL lockstep_stream: cycles=%0d want 17, a_beats=%0d b_beats=%0d sent=%0d want 16",
               cyc, da.size(), db.size(), sent.size());
    end else pass_cnt++;
  endtask

  task automatic test_stall_b();
    int k = 0;
    bit acc;
    clear_sb();
    a_ready = 1'b1; b_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      in_valid = (k < 6);
      in_vec   = mk(100 + 4 * k);
      tick(acc);
      if (acc) k++;
    end
    total_cnt++;
    if (k != 4 || in_ready !== 1'b0 || b_count !== 3'd4 || a_count !== 3'd0) begin
      $display("FAIL stall_b_fill: accepted=%0d rdy=%b bc=%0d ac=%0d, want 4 0 4 0",
               k, in_ready, b_count, a_count);
    end else pass_cnt++;
    b_ready = 1'b1;
    in_vec  = mk(100 + 4 * k);
    total_cnt++;
    if (in_ready !== 1'b0 || b_vec !== mk(100)) begin
      $display("FAIL stall_b_head: rdy=%b b=%h, want 0 %h", in_ready, b_vec, mk(100));
    end else pass_cnt++;
    tick(acc);
    if (acc) k++;
    total_cnt++;
    if (in_ready !== 1'b1 || b_count !== 3'd3) begin
      $display("FAIL stall_b_reopen: rdy=%b bc=%0d, want 1 3", in_ready, b_count);
    end else pass_cnt++;
    for (int c = 0; c < 40 && (k < 6 || qa.size() > 0 || qb.size() > 0); c++) begin
      in_valid = (k < 6);
      in_vec   = mk(100 + 4 * k);
      total_cnt++;
      if (b_valid !== (qb.size() > 0) || (qb.size() > 0 && b_vec !== qb[0])) begin
        $display("FAIL stall_b_drain: cyc %0d bv=%b b=%h, want valid=%0d", c, b_valid, b_vec, qb.size() > 0);
      end else pass_cnt++;
      tick(acc);
      if (acc) k++;
    end
    total_cnt++;
    if (sent.size() != 6 || da != sent || db != sent) begin
      $display("FAIL stall_b_order: sent=%0d a_beats=%0d b_beats=%0d, want 6 in order",
               sent.size(), da.size(), db.size());
    end else pass_cnt++;
  endtask

  task automatic test_full_simul();
    int k = 0;
    bit acc;
    clear_sb();
    a_ready = 1'b0; b_ready = 1'b1;
    for (int c = 0; c < 10 && k < 4; c++) begin
      in_valid = 1'b1;
      in_vec   = mk(200 + 4 * k);
      tick(acc);
      if (acc) k++;
    end
    total_cnt++;
    if (a_count !== 3'd4 || in_ready !== 1'b0) begin
      $display("FAIL full_setup: ac=%0d rdy=%b, want 4 0", a_count, in_ready);
    end else pass_cnt++;
    in_valid = 1'b1; in_vec = mk(216); a_ready = 1'b1;
    tick(acc);
    total_cnt++;
    if (a_count !== 3'd3 || in_ready !== 1'b1) begin
      $display("FAIL full_simul_pop: ac=%0d rdy=%b, want 3 1", a_count, in_ready);
    end else pass_cnt++;
    a_ready = 1'b0;
    tick(acc);
    in_valid = 1'b0;
    total_cnt++;
    if (a_count !== 3'd4) begin
      $display("FAIL full_next_push: ac=%0d want 4", a_count);
    end else pass_cnt++;
    drain();
    total_cnt++;
    if (sent.size() != 5 || da != sent || db != sent) begin
      $display("FAIL full_order: sent=%0d a_beats=%0d b_beats=%0d, want 5 in order",
               sent.size(), da.size(), db.size());
    end else pass_cnt++;
  endtask

  task automatic test_wrap();
    int k = 0;
    int bad = 0;
    int diff;
    bit acc;
    clear_sb();
    for (int c = 0; c < 400 && (k < 20 || qa.size() > 0 || qb.size() > 0); c++) begin
      in_valid = (k < 20) && ($urandom_range(0, 3) != 0);
      in_vec   = vec_t'({$urandom, $urandom});
      a_ready  = $urandom_range(0, 1) == 1;
      b_ready  = $urandom_range(0, 1) == 1;
      diff = int'(a_count) - int'(b_count);
      if (in_ready !== ((qa.size() < DEPTH) && (qb.size() < DEPTH)) ||
          a_count !== 3'(qa.size()) || b_count !== 3'(qb.size()) ||
          a_valid !== (qa.size() > 0) || b_valid !== (qb.size() > 0) ||
          (qa.size() > 0 && a_vec !== qa[0]) || (qb.size() > 0 && b_vec !== qb[0]) ||
          diff > 4 || diff < -4) begin
        if (bad == 0)
          $display("FAIL wrap_cycle: cyc %0d rdy=%b ac=%0d bc=%0d a=%h b=%h, want rdy/counts %0d/%0d",
                   c, in_ready, a_count, b_count, a_vec, b_vec, qa.size(), qb.size());
        bad++;
      end
      tick(acc);
      if (acc) k++;
    end
    total_cnt++;
    if (bad != 0) begin
      $display("FAIL wrap_cycles: %0d bad cycles, want 0", bad);
    end else pass_cnt++;
    total_cnt++;
    if (sent.size() != 20 || da != sent || db != sent) begin
      $display("FAIL wrap_order: sent=%0d a_beats=%0d b_beats=%0d, want 20 in order",
               sent.size(), da.size(), db.size());
    end else pass_cnt++;
  endtask

  task automatic test_hold();
    bit acc;
    a_ready = 1'b0; b_ready = 1'b1;
    in_valid = 1'b1; in_vec = mk(16);
    tick(acc);
    in_valid = 1'b0;
    in_vec   = mk(500);
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if (a_valid !== 1'b1 || a_vec !== mk(16)) begin
        $display("FAIL hold_cycle: cyc %0d av=%b a=%h, want 1 %h", i, a_valid, a_vec, mk(16));
      end else pass_cnt++;
      tick(acc);
    end
    drain();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_vec = '0; a_ready = 1'b0; b_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_lockstep();
    test_stall_b();
    test_full_simul();
    test_wrap();
    test_hold();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
